// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch PC generator and IF/ID pipeline register
// Optional misaligned-target flag enabled by defining INST_ALIGN_CHK_EN.
module if_stage #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_if,
   input  logic              stall_id,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] pc_o,
   input  logic [INST_W-1:0] inst_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_valid_o,
   output logic              id_excp_o
);

`ifdef INST_ALIGN_CHK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   localparam logic [ADDR_W-1:0] RESET_PC_AL = {RESET_PC[ADDR_W-1:2], 2'b00};

   logic              ce_q, ce_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [INST_W-1:0] id_inst_q, id_inst_d;
   logic              id_valid_q, id_valid_d;
   logic              id_excp_q, id_excp_d;

   always_comb begin
      ce_d  = 1'b1;
      pc_d  = pc_q;
      err_d = err_q;
      if (!ce_q) begin
         pc_d  = RESET_PC_AL;
         err_d = 1'b0;
      end else if (flush) begin
         pc_d  = {new_pc[ADDR_W-1:2], 2'b00};
         err_d = ALIGN_CHK && (|new_pc[1:0]);
      end else if (stall_if) begin
         pc_d  = pc_q;
      end else if (branch_flag_i) begin
         pc_d  = {branch_target_address_i[ADDR_W-1:2], 2'b00};
         err_d = ALIGN_CHK && (|branch_target_address_i[1:0]);
      end else begin
         // sequential fetch: the error flag belonged only to the redirected fetch
         pc_d  = pc_q + ADDR_W'(4);
         err_d = 1'b0;
      end
   end

   always_comb begin
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      id_excp_d  = id_excp_q;
      if (flush || (stall_if && !stall_id)) begin
         id_pc_d    = '0;
         id_inst_d  = '0;
         id_valid_d = 1'b0;
         id_excp_d  = 1'b0;
      end else if (!stall_if) begin
         id_pc_d    = pc_q;
         id_inst_d  = inst_i;
         id_valid_d = ce_q;
         id_excp_d  = err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ce_q       <= 1'b0;
         pc_q       <= RESET_PC_AL;
         err_q      <= 1'b0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
         id_excp_q  <= 1'b0;
      end else begin
         ce_q       <= ce_d;
         pc_q       <= pc_d;
         err_q      <= err_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         id_excp_q  <= id_excp_d;
      end
   end

   assign rom_ce_o   = ce_q;
   assign pc_o       = pc_q;
   assign id_pc_o    = id_pc_q;
   assign id_inst_o  = id_inst_q;
   assign id_valid_o = id_valid_q;
   assign id_excp_o  = id_excp_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with a reference fetch model
module tb_if_stage;

`ifdef INST_ALIGN_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, stall_if, stall_id, flush, branch_flag_i;
   logic [31:0] new_pc, branch_target_address_i;
   logic        rom_ce_o, id_valid_o, id_excp_o;
   logic [31:0] pc_o, inst_i, id_pc_o, id_inst_o;

   int errors = 0;
   int checks = 0;

   // reference model state
   bit          m_ce, m_err, m_valid, m_excp;
   bit [31:0]   m_pc, m_id_pc, m_id_inst;

   if_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
      .flush(flush), .new_pc(new_pc), .branch_flag_i(branch_flag_i),
      .branch_target_address_i(branch_target_address_i),
      .rom_ce_o(rom_ce_o), .pc_o(pc_o), .inst_i(inst_i),
      .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o),
      .id_excp_o(id_excp_o)
   );

   always #5 clk = ~clk;
   assign inst_i = pc_o + 32'd1;

   function automatic bit misaligned(input bit [31:0] a);
      return CHK && (a % 4 != 0);
   endfunction

   // One clock edge; the model advances from the inputs in force before the edge.
   task automatic tick();
      bit        n_ce, n_err;
      bit [31:0] n_pc;
      if (rst) begin
         n_ce = 0; n_pc = 0; n_err = 0;
         m_id_pc = 0; m_id_inst = 0; m_valid = 0; m_excp = 0;
      end else begin
         if (flush || (stall_if && !stall_id)) begin
            m_id_pc = 0; m_id_inst = 0; m_valid = 0; m_excp = 0;
         end else if (!stall_if) begin
            m_id_pc = m_pc; m_id_inst = m_pc + 1; m_valid = m_ce; m_excp = m_err;
         end
         n_ce = 1; n_pc = m_pc; n_err = m_err;
         if (!m_ce) begin n_pc = 0; n_err = 0; end
         else if (flush) begin n_pc = new_pc - new_pc % 4; n_err = misaligned(new_pc); end
         else if (stall_if) begin end
         else if (branch_flag_i) begin
            n_pc = branch_target_address_i - branch_target_address_i % 4;
            n_err = misaligned(branch_target_address_i);
         end else begin n_pc = m_pc + 4; n_err = 0; end
      end
      m_ce = n_ce; m_pc = n_pc; m_err = n_err;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; stall_if = 0; stall_id = 0; flush = 0; branch_flag_i = 0;
      new_pc = 0; branch_target_address_i = 0;
   endtask

   // reset, then run until pc_o = 32'hC with IF/ID holding address 8
   task automatic start_to_c();
      idle_inputs(); rst = 1; tick(); tick(); rst = 0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1; tick(); tick();
      checks++; if (rom_ce_o !== 1'b0) begin errors++; $display("FAIL reset_ce got %0b want 0", rom_ce_o); end
      checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc_o); end
      checks++; if ({id_pc_o, id_inst_o, id_valid_o, id_excp_o} !== 66'h0) begin errors++;
         $display("FAIL reset_ifid got %h %h %b %b want zeros", id_pc_o, id_inst_o, id_valid_o, id_excp_o); end
      rst = 0; tick();
      checks++; if (rom_ce_o !== 1'b1 || pc_o !== 32'h0 || id_valid_o !== 1'b0) begin errors++;
         $display("FAIL first_edge got ce=%b pc=%h v=%b want 1 0 0", rom_ce_o, pc_o, id_valid_o); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (pc_o !== 32'(4*i) || id_inst_o !== 32'(4*i-3) || id_valid_o !== 1'b1) begin errors++;
            $display("FAIL seq_fetch%0d got pc=%h inst=%h v=%b want %h %h 1", i, pc_o, id_inst_o, id_valid_o, 4*i, 4*i-3); end
      end
   endtask

   task automatic test_branch();
      idle_inputs(); rst = 1; tick(); rst = 0; repeat (3) tick();
      branch_flag_i = 1; branch_target_address_i = 32'h100; tick(); branch_flag_i = 0;
      checks++; if (pc_o !== 32'h100 || id_pc_o !== 32'h8 || id_inst_o !== 32'h9 || id_valid_o !== 1'b1) begin errors++;
         $display("FAIL branch_delay_slot got pc=%h id_pc=%h inst=%h v=%b want 100 8 9 1", pc_o, id_pc_o, id_inst_o, id_valid_o); end
      tick();
      checks++; if (pc_o !== 32'h104 || id_pc_o !== 32'h100 || id_inst_o !== 32'h101) begin errors++;
         $display("FAIL branch_target got pc=%h id_pc=%h inst=%h want 104 100 101", pc_o, id_pc_o, id_inst_o); end
   endtask

   task automatic test_stall_bubble();
      start_to_c();
      stall_if = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (pc_o !== 32'hC || id_valid_o !== 1'b0 || id_inst_o !== 32'h0 || id_pc_o !== 32'h0) begin errors++;
            $display("FAIL bubble%0d got pc=%h v=%b inst=%h id_pc=%h want C 0 0 0", i, pc_o, id_valid_o, id_inst_o, id_pc_o); end
      end
      stall_if = 0; tick();
      checks++; if (pc_o !== 32'h10 || id_pc_o !== 32'hC || id_inst_o !== 32'hD || id_valid_o !== 1'b1) begin errors++;
         $display("FAIL bubble_release got pc=%h id_pc=%h inst=%h v=%b want 10 C D 1", pc_o, id_pc_o, id_inst_o, id_valid_o); end
   endtask

   task automatic test_stall_hold();
      start_to_c();
      stall_if = 1; stall_id = 1; branch_flag_i = 1; branch_target_address_i = 32'h300;
      tick(); tick();
      checks++; if (pc_o !== 32'hC || id_pc_o !== 32'h8 || id_inst_o !== 32'h9 || id_valid_o !== 1'b1) begin errors++;
         $display("FAIL stall_hold got pc=%h id_pc=%h inst=%h v=%b want C 8 9 1", pc_o, id_pc_o, id_inst_o, id_valid_o); end
      stall_if = 0; stall_id = 0; tick(); branch_flag_i = 0;
      checks++; if (pc_o !== 32'h300 || id_pc_o !== 32'hC) begin errors++;
         $display("FAIL stall_then_branch got pc=%h id_pc=%h want 300 C", pc_o, id_pc_o); end
   endtask

   task automatic test_flush_priority();
      start_to_c();
      flush = 1; new_pc = 32'h20; stall_if = 1; branch_flag_i = 1; branch_target_address_i = 32'h100;
      tick(); idle_inputs();
      checks++; if (pc_o !== 32'h20 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0 || id_inst_o !== 32'h0) begin errors++;
         $display("FAIL flush_prio got pc=%h v=%b id_pc=%h inst=%h want 20 0 0 0", pc_o, id_valid_o, id_pc_o, id_inst_o); end
      tick();
      checks++; if (pc_o !== 32'h24 || id_pc_o !== 32'h20 || id_inst_o !== 32'h21 || id_valid_o !== 1'b1) begin errors++;
         $display("FAIL flush_next got pc=%h id_pc=%h inst=%h v=%b want 24 20 21 1", pc_o, id_pc_o, id_inst_o, id_valid_o); end
      tick();
      checks++; if (pc_o !== 32'h28) begin errors++; $display("FAIL flush_seq got pc=%h want 28", pc_o); end
   endtask

   task automatic test_wrap();
      start_to_c();
      flush = 1; new_pc = 32'hFFFF_FFF8; tick(); flush = 0;
      checks++; if (pc_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap0 got %h want FFFFFFF8", pc_o); end
      tick();
      checks++; if (pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap1 got %h want FFFFFFFC", pc_o); end
      tick();
      checks++; if (pc_o !== 32'h0 || id_inst_o !== 32'hFFFF_FFFD) begin errors++;
         $display("FAIL wrap2 got pc=%h inst=%h want 0 FFFFFFFD", pc_o, id_inst_o); end
   endtask

   task automatic test_align();
      start_to_c();
      branch_flag_i = 1; branch_target_address_i = 32'h102; tick(); branch_flag_i = 0;
      checks++; if (pc_o !== 32'h100 || id_excp_o !== 1'b0) begin errors++;
         $display("FAIL align_redirect got pc=%h excp=%b want 100 0", pc_o, id_excp_o); end
      tick();
      checks++; if (id_pc_o !== 32'h100 || id_excp_o !== CHK) begin errors++;
         $display("FAIL align_flag got id_pc=%h excp=%b want 100 %b", id_pc_o, id_excp_o, CHK); end
      tick();
      checks++; if (id_excp_o !== 1'b0) begin errors++; $display("FAIL align_clear got %b want 0", id_excp_o); end
      flush = 1; new_pc = 32'h23; tick(); flush = 0; tick();
      checks++; if (id_pc_o !== 32'h20 || id_excp_o !== CHK) begin errors++;
         $display("FAIL align_flush got id_pc=%h excp=%b want 20 %b", id_pc_o, id_excp_o, CHK); end
   endtask

   task automatic test_reset_mid();
      start_to_c();
      rst = 1; flush = 1; new_pc = 32'h40; stall_if = 1; branch_flag_i = 1; tick(); idle_inputs();
      checks++; if (rom_ce_o !== 1'b0 || pc_o !== 32'h0 || id_valid_o !== 1'b0 || id_pc_o !== 32'h0) begin errors++;
         $display("FAIL reset_mid got ce=%b pc=%h v=%b id_pc=%h want 0 0 0 0", rom_ce_o, pc_o, id_valid_o, id_pc_o); end
      tick(); tick();
      checks++; if (pc_o !== 32'h4 || id_pc_o !== 32'h0 || id_valid_o !== 1'b1) begin errors++;
         $display("FAIL reset_restart got pc=%h id_pc=%h v=%b want 4 0 1", pc_o, id_pc_o, id_valid_o); end
   endtask

   task automatic test_random();
      idle_inputs(); rst = 1; tick(); rst = 0;
      for (int n = 0; n < 400; n++) begin
         rst           = ($urandom_range(63) == 0);
         flush         = ($urandom_range(15) == 0);
         stall_if      = ($urandom_range(4) == 0);
         stall_id      = $urandom_range(1);
         branch_flag_i = ($urandom_range(5) == 0);
         new_pc        = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
         branch_target_address_i = $urandom;
         tick();
         checks++; if (rom_ce_o !== m_ce || pc_o !== m_pc) begin errors++;
            $display("FAIL rand_pc cyc%0d got ce=%b pc=%h want %b %h", n, rom_ce_o, pc_o, m_ce, m_pc); end
         checks++; if (id_pc_o !== m_id_pc || id_inst_o !== m_id_inst) begin errors++;
            $display("FAIL rand_ifid cyc%0d got %h %h want %h %h", n, id_pc_o, id_inst_o, m_id_pc, m_id_inst); end
         checks++; if (id_valid_o !== m_valid || id_excp_o !== m_excp) begin errors++;
            $display("FAIL rand_flags cyc%0d got v=%b e=%b want %b %b", n, id_valid_o, id_excp_o, m_valid, m_excp); end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      #1;
      test_reset();
      test_branch();
      test_stall_bubble();
      test_stall_hold();
      test_flush_priority();
      test_wrap();
      test_align();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
